// File: rtl/display_pkg.sv
// ============================================================================
// Module  : display_pkg
// Brief   : Shared constants and state encoding for the display scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int NIBBLE_W = 4;

    // Wide enough for the largest supported digit count; users slice it down.
    localparam logic [7:0] DIGIT_OFF = 8'hFF;

    typedef logic [0:0] state_t;

    localparam state_t SHOW = 1'b0;
    localparam state_t GAP  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module  : tick_gen
// Brief   : Modulo-MAX counter with sync clear/enable and terminal-count flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (MAX > 1) ? $clog2(MAX) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign tc = (r_cnt == CNT_W'(MAX - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_scan.sv
// ============================================================================
// Module  : display_scan
// Brief   : Multiplexed seven-segment digit scanner with dead time, leading-
//           zero blanking and frame-boundary (tear-free) value update.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan
    import display_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000,
    parameter int GAP_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [NIBBLE_W*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]          dp_in,
    input  logic                       blank_lz,
    output logic [NIBBLE_W-1:0]        number,
    output logic                       dp,
    output logic [DIGITS-1:0]          digit_sel_n,
    output logic                       blank,
    output logic                       frame_done
);

    localparam int                 IDX_W      = $clog2(DIGITS);
    localparam int                 VAL_W      = NIBBLE_W * DIGITS;
    localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(DIGITS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_advance;
    logic                w_wrap;
    logic                w_pre_tc;
    logic                w_gap_tc;
    logic [IDX_W-1:0]    r_idx;
    logic [VAL_W-1:0]    r_shadow_val;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [VAL_W-1:0]    r_active_val;
    logic [DIGITS-1:0]   r_active_dp;
    logic                r_frame_done;
    logic                r_blank_lz;
    logic                w_upper_zero;
    logic                w_lz_blank;
    logic                w_lit;

    tick_gen #(.MAX(PRESCALE)) u_prescale (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (r_state != SHOW),
        .en    (1'b1),
        .tc    (w_pre_tc)
    );

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            tick_gen #(.MAX(GAP_CYCLES)) u_gap (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (r_state != GAP),
                .en    (1'b1),
                .tc    (w_gap_tc)
            );
        end else begin : g_no_gap
            assign w_gap_tc = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SHOW;
        end else begin
            r_state <= w_next_state;
        end
    end

    // w_advance marks the edge on which the next digit's SHOW begins.
    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        case (r_state)
            SHOW: begin
                if (w_pre_tc) begin
                    if (GAP_CYCLES > 0) begin
                        w_next_state = GAP;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            GAP: begin
                if (w_gap_tc) begin
                    w_next_state = SHOW;
                    w_advance    = 1'b1;
                end
            end
            default: w_next_state = SHOW;
        endcase
    end

    assign w_wrap = w_advance && (r_idx == c_LAST_IDX);

    // Active only swaps on the wrap, so a frame never mixes two values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_active_val <= '0;
            r_active_dp  <= '0;
            r_frame_done <= 1'b0;
            r_blank_lz   <= 1'b0;
        end else begin
            r_blank_lz   <= blank_lz;
            r_frame_done <= w_wrap;
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end
            if (w_advance) begin
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            if (w_wrap) begin
                r_active_val <= r_shadow_val;
                r_active_dp  <= r_shadow_dp;
            end
        end
    end

    always_comb begin
        w_upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) >= r_idx) && (r_active_val[i*NIBBLE_W +: NIBBLE_W] != '0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_lz_blank = r_blank_lz && w_upper_zero && (r_idx != '0);
    assign w_lit      = (r_state == SHOW) && !w_lz_blank;

    always_comb begin
        number      = r_active_val[r_idx*NIBBLE_W +: NIBBLE_W];
        dp          = w_lz_blank ? 1'b0 : r_active_dp[r_idx];
        digit_sel_n = w_lit ? ~(DIGITS'(1) << r_idx) : DIGIT_OFF[DIGITS-1:0];
        blank       = !w_lit;
        frame_done  = r_frame_done;
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scan.sv
// ============================================================================
// Module  : tb_display_scan
// Brief   : Scoreboard bench for display_scan (gap=1 and gap=0 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;

    logic [3:0]  w_num0, w_num1;
    logic        w_dp0, w_dp1;
    logic [3:0]  w_sel0, w_sel1;
    logic        w_blank0, w_blank1;
    logic        w_fd0, w_fd1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        int         dut;
        logic [3:0] sel;
        logic [3:0] num;
        logic       dp;
        logic       blank;
        logic       fd;
        string      name;
    } exp_t;

    exp_t sbq[$];

    display_scan #(.DIGITS(4), .PRESCALE(4), .GAP_CYCLES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .number(w_num0), .dp(w_dp0), .digit_sel_n(w_sel0),
        .blank(w_blank0), .frame_done(w_fd0)
    );

    display_scan #(.DIGITS(4), .PRESCALE(4), .GAP_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .number(w_num1), .dp(w_dp1), .digit_sel_n(w_sel1),
        .blank(w_blank1), .frame_done(w_fd1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic push(input int c, input int d, input logic [3:0] s, input logic [3:0] n,
                        input logic p, input logic b, input logic f, input string nm);
        exp_t e;
        e.cyc = c; e.dut = d; e.sel = s; e.num = n; e.dp = p; e.blank = b; e.fd = f; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic check_entry(input exp_t e);
        logic [3:0] a_sel, a_num;
        logic       a_dp, a_blank, a_fd;
        checks++;
        if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s c%0d: not sampled (now cycle %0d)", e.name, e.cyc, cyc);
            return;
        end
        a_sel   = (e.dut == 0) ? w_sel0   : w_sel1;
        a_num   = (e.dut == 0) ? w_num0   : w_num1;
        a_dp    = (e.dut == 0) ? w_dp0    : w_dp1;
        a_blank = (e.dut == 0) ? w_blank0 : w_blank1;
        a_fd    = (e.dut == 0) ? w_fd0    : w_fd1;
        if (a_sel !== e.sel || a_num !== e.num || a_dp !== e.dp ||
            a_blank !== e.blank || a_fd !== e.fd) begin
            errors++;
            $display("FAIL %s c%0d dut%0d: got sel=%b num=%h dp=%b blank=%b fd=%b, want sel=%b num=%h dp=%b blank=%b fd=%b",
                     e.name, e.cyc, e.dut, a_sel, a_num, a_dp, a_blank, a_fd,
                     e.sel, e.num, e.dp, e.blank, e.fd);
        end
    endtask

    // Monitor: consumes every expectation whose cycle has arrived.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = sbq.size() - 1; k >= 0; k--) begin
                if (sbq[k].cyc <= cyc) begin
                    check_entry(sbq[k]);
                    sbq.delete(k);
                end
            end
        end
    end

    task automatic at_cycle(input int c);
        int guard = 0;
        while (cyc != c && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("FAIL at_cycle: reached %0d, wanted %0d", cyc, c);
        end
    endtask

    task automatic do_load(input int c, input logic [15:0] v, input logic [3:0] d);
        at_cycle(c);
        load = 1'b1; value = v; dp_in = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // Reset, first load at cycle 3, boundary-coincident load at cycle 19
        blank_lz = 1'b0;
        rst_n = 1'b0;
        push(0,  0, 4'b1110, 4'h0, 0, 0, 0, "rst_c0");
        push(3,  0, 4'b1110, 4'h0, 0, 0, 0, "rst_c3");
        push(4,  0, 4'b1111, 4'h0, 0, 1, 0, "rst_gap");
        push(5,  0, 4'b1101, 4'h0, 0, 0, 0, "rst_d1");
        push(19, 0, 4'b1111, 4'h0, 0, 1, 0, "pre_frame");
        push(20, 0, 4'b1110, 4'h4, 0, 0, 1, "f1_d0");
        push(21, 0, 4'b1110, 4'h4, 0, 0, 0, "fd_one");
        push(24, 0, 4'b1111, 4'h4, 0, 1, 0, "gap_hold0");
        push(25, 0, 4'b1101, 4'h3, 1, 0, 0, "f1_d1");
        push(29, 0, 4'b1111, 4'h3, 1, 1, 0, "gap_hold1");
        push(30, 0, 4'b1011, 4'h2, 0, 0, 0, "f1_d2");
        push(35, 0, 4'b0111, 4'h1, 0, 0, 0, "f1_d3");
        push(40, 0, 4'b1110, 4'hD, 0, 0, 1, "f2_d0");
        push(45, 0, 4'b1101, 4'hC, 0, 0, 0, "f2_d1");
        push(50, 0, 4'b1011, 4'hB, 0, 0, 0, "f2_d2");
        push(55, 0, 4'b0111, 4'hA, 1, 0, 0, "f2_d3");
        for (int c = 0; c < 16; c++) begin
            logic [3:0] one;
            one = 4'b0001;
            push(c, 1, ~(one << (c / 4)), 4'h0, 0, 0, 0, "g0_scan");
        end
        push(16, 1, 4'b1110, 4'h4, 0, 0, 1, "g0_f1_d0");
        push(20, 1, 4'b1101, 4'h3, 1, 0, 0, "g0_f1_d1");
        push(32, 1, 4'b1110, 4'hD, 0, 0, 1, "g0_f2_d0");
        push(44, 1, 4'b0111, 4'hA, 1, 0, 0, "g0_f2_d3");
        @(negedge clk);
        rst_n = 1'b1;
        do_load(3,  16'h1234, 4'b0010);
        do_load(19, 16'hABCD, 4'b1000);
        at_cycle(58);

        // Leading-zero blanking on and off
        @(negedge clk);
        rst_n = 1'b0;
        blank_lz = 1'b1;
        push(20, 0, 4'b1110, 4'h0, 0, 0, 1, "lz50_d0");
        push(25, 0, 4'b1101, 4'h5, 0, 0, 0, "lz50_d1");
        push(30, 0, 4'b1111, 4'h0, 0, 1, 0, "lz50_d2");
        push(35, 0, 4'b1111, 4'h0, 0, 1, 0, "lz50_d3");
        push(40, 0, 4'b1110, 4'h0, 0, 0, 1, "lz0_d0");
        push(45, 0, 4'b1111, 4'h0, 0, 1, 0, "lz0_d1");
        push(50, 0, 4'b1111, 4'h0, 0, 1, 0, "lz0_d2");
        push(55, 0, 4'b1111, 4'h0, 0, 1, 0, "lz0_d3");
        push(60, 0, 4'b1110, 4'h0, 0, 0, 1, "nolz50_d0");
        push(65, 0, 4'b1101, 4'h5, 0, 0, 0, "nolz50_d1");
        push(70, 0, 4'b1011, 4'h0, 0, 0, 0, "nolz50_d2");
        push(75, 0, 4'b0111, 4'h0, 0, 0, 0, "nolz50_d3");
        push(80, 0, 4'b1110, 4'h0, 0, 0, 1, "nolz0_d0");
        push(85, 0, 4'b1101, 4'h0, 0, 0, 0, "nolz0_d1");
        push(90, 0, 4'b1011, 4'h0, 0, 0, 0, "nolz0_d2");
        push(95, 0, 4'b0111, 4'h0, 0, 0, 0, "nolz0_d3");
        @(negedge clk);
        rst_n = 1'b1;
        do_load(0,  16'h0050, 4'b0000);
        do_load(25, 16'h0000, 4'b0000);
        at_cycle(58);
        blank_lz = 1'b0;
        do_load(58, 16'h0050, 4'b0000);
        do_load(78, 16'h0000, 4'b0000);
        at_cycle(98);

        // Mid-frame reset with a concurrent load that must be ignored
        @(negedge clk);
        rst_n = 1'b0;
        push(25, 0, 4'b1101, 4'h3, 1, 0, 0, "pre_rst_d1");
        @(negedge clk);
        rst_n = 1'b1;
        do_load(3, 16'h1234, 4'b0010);
        at_cycle(27);
        rst_n = 1'b0;
        load = 1'b1; value = 16'hFFFF; dp_in = 4'b1111;
        push(0,  0, 4'b1110, 4'h0, 0, 0, 0, "mrst_c0");
        push(3,  0, 4'b1110, 4'h0, 0, 0, 0, "mrst_c3");
        push(4,  0, 4'b1111, 4'h0, 0, 1, 0, "mrst_gap");
        push(5,  0, 4'b1101, 4'h0, 0, 0, 0, "mrst_d1");
        push(19, 0, 4'b1111, 4'h0, 0, 1, 0, "mrst_c19");
        push(20, 0, 4'b1110, 4'h0, 0, 0, 1, "mrst_shadow0");
        push(25, 0, 4'b1101, 4'h0, 0, 0, 0, "mrst_f1_d1");
        push(0,  1, 4'b1110, 4'h0, 0, 0, 0, "g0_mrst_c0");
        push(4,  1, 4'b1101, 4'h0, 0, 0, 0, "g0_mrst_c4");
        push(16, 1, 4'b1110, 4'h0, 0, 0, 1, "g0_mrst_f1");
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b0;
        at_cycle(30);

        for (int g = 0; g < 100 && sbq.size() != 0; g++) @(negedge clk);
        while (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s c%0d: expectation never consumed", sbq[0].name, sbq[0].cyc);
            void'(sbq.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/display_scan.md
Name: display_scan

Overview:
- Time-multiplexed scanner for a common-anode multi-digit seven-segment display.
- Holds a DIGITS-nibble value, walks the digits one at a time and presents each 4-bit nibble on number, which feeds the hex-to-segment decoder (semisegment) directly downstream.
- Drives active-low digit enables, a dead-time gap between digits against ghosting, optional leading-zero blanking, and a tear-free frame-boundary update.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
PRESCALE, 50000, clock cycles each digit stays lit (>=2)
GAP_CYCLES, 16, clock cycles with all digits off between digits (0 allowed)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
load  in  1  one-cycle strobe, capture value/dp_in into shadow register
value  in  4*DIGITS  hex value; nibble i drives digit i, digit 0 least significant
dp_in  in  DIGITS  decimal-point request per digit
blank_lz  in  1  enable leading-zero blanking (sampled live, not shadowed)
number  out  4  nibble of the currently selected digit, to semisegment
dp  out  1  decimal point for the current digit
digit_sel_n  out  DIGITS  active-low one-hot digit enable, all ones when off
blank  out  1  high while no digit is enabled (GAP or blanked digit)
frame_done  out  1  one-cycle pulse at the start of each new frame

Behaviour:
- One clock domain; all state changes on rising clk; reset synchronous, active-low, with priority over load.
- Outputs are decoded from registered state only, with no combinational path from inputs to outputs.
- Registers: shadow and active (each 4*DIGITS value plus DIGITS dp bits), idx (clog2(DIGITS) bits), prescale counter, gap counter, FSM state.
- Reset values: state=SHOW, idx=0, counters=0, shadow=active=0, frame_done=0.
- Therefore, first cycle after reset: number=0, dp=0, digit_sel_n=...1110, blank=0.
- load: shadow <= {value, dp_in} on the edge where load=1. active changes only at a frame boundary.
- FSM state SHOW:
  - prescale counter counts 0..PRESCALE-1.
  - When count==PRESCALE-1, the next state is GAP (or the next SHOW directly if GAP_CYCLES=0). The counter clears on leaving SHOW.
  - SHOW therefore lasts exactly PRESCALE cycles.
- FSM state GAP:
  - digit_sel_n all ones, blank=1, and number/dp hold the last digit's values.
  - The gap counter counts 0..GAP_CYCLES-1, then the next state is SHOW with idx advanced.
- idx advance: idx <= idx+1, wrapping from DIGITS-1 to 0.
- Frame boundary (on the wrap to 0):
  - active <= shadow on the same edge.
  - frame_done=1 for exactly the first SHOW cycle of digit 0.
- Load coinciding with the frame-boundary edge: active takes the pre-edge shadow; the new value appears one frame later. No partial frame ever shows a mix of two values.
- Digit period = PRESCALE+GAP_CYCLES; frame period = DIGITS*(PRESCALE+GAP_CYCLES).
- In SHOW: number = active nibble idx, dp = active dp bit idx, digit_sel_n = ~(1<<idx).
- Leading-zero blanking: when blank_lz=1 and active nibbles DIGITS-1 down to idx are all zero with idx!=0:
  - digit_sel_n all ones, blank=1, dp=0.
  - Timing is unchanged.
  - Digit 0 is never blanked, so the value 0 shows a single "0".
- Reset asserted mid-frame: on that edge everything returns to reset values. The next frame starts at digit 0 with active=0, and no frame_done pulse is generated for it.

Decomposition:
- Shared package (display_pkg):
  - FSM state encoding SHOW/GAP (1 bit).
  - Constants DIGIT_OFF (all-ones select) and NIBBLE_W=4.
- Sub-module tick_gen(MAX): counter with synchronous clear/enable and a terminal-count output. It is instantiated twice, once for prescale and once for gap.
- semisegment is instantiated by the parent, not inside this block.

Test Plan:
Setup for all scenarios: DIGITS=4, PRESCALE=4, GAP_CYCLES=1, so one frame is 20 cycles.
- Reset: release rst_n at cycle 0.
  - Cycles 0-3: digit_sel_n=1110, number=0, blank=0.
  - Cycle 4: digit_sel_n=1111, blank=1.
  - Cycle 5: digit_sel_n=1101.
  - No frame_done until cycle 20.
- Load 0x1234 with dp_in=0010 at cycle 3:
  - Digits read 0 until cycle 19.
  - Cycle 20: frame_done=1, number=4, sel=1110, dp=0.
  - Cycle 25: number=3, sel=1101, dp=1.
  - Cycles 30 and 35: number=2, then 1.
- Load at the frame-boundary edge (cycle 19, value 0xABCD, after a prior 0x1234):
  - Frame at cycle 20 still shows 1234.
  - Cycle 40 onward shows D,C,B,A.
- Leading-zero blanking with blank_lz=1:
  - Value 0x0050: digits 3 and 2 have sel=1111 and blank=1; digit 1 shows 5; digit 0 shows 0.
  - Value 0x0000: only digit 0 is lit, number=0.
  - Same values with blank_lz=0: all four digits are lit.
- GAP_CYCLES=0 variant: sel goes 1110 to 1101 on adjacent cycles 3 to 4; blank never rises.
- Reset mid-frame:
  - Assert rst_n=0 for one cycle at cycle 27. Next cycle: sel=1110, number=0, counters restarted.
  - A concurrent load during the reset cycle is ignored (shadow=0).
